// File: rtl/grf_arb_pkg.sv
// Shared types and constants for the GRF write-port arbiter.
package grf_arb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WAIT_W     = 3;

  // Identity of the requester that owns a given GRF write.
  typedef enum logic {
    SRC_P = 1'b0,
    SRC_M = 1'b1
  } src_e;

  // One writeback request: destination, data and the PC used for tracing.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] a3;
    logic [DATA_W-1:0]     wd;
    logic [DATA_W-1:0]     pc;
  } wr_req_t;

  // $0 is hardwired to zero, so a write to it is accepted but not performed.
  function automatic logic is_real_write(input logic [REG_ADDR_W-1:0] a3);
    return a3 != '0;
  endfunction

endpackage

// File: rtl/grf_arb_wait_ctr.sv
// Starvation guard for the M requester: counts consecutive refused cycles,
// saturating at MAX_WAIT, and raises force_o once M has waited long enough.
module grf_arb_wait_ctr
  import grf_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic m_valid_i,
  input  logic m_ready_i,
  output logic force_o,
  output logic m_starved_o
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              starved_q, starved_d;

  // Next count: clear on an M transfer, count refusals, hold while M is idle.
  always_comb begin
    cnt_d = cnt_q;
    if (m_valid_i && m_ready_i) begin
      cnt_d = '0;
    end else if (m_valid_i && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
    starved_d = (cnt_d == MAX_CNT);
  end

  // Counter and starved flag registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      starved_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      starved_q <= starved_d;
    end
  end

  assign force_o     = (cnt_q == MAX_CNT);
  assign m_starved_o = starved_q;

endmodule

// File: rtl/grf_write_arbiter.sv
// Arbitrates the single GRF write port between the pipeline writeback (P)
// and the multiply/divide unit (M), presenting one registered write per cycle.
// Define GRF_ARB_RR_EN for round-robin; otherwise fixed priority to P with a
// starvation guard that force-grants M after MAX_WAIT refusals.
module grf_write_arbiter
  import grf_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p_valid,
  output logic                  p_ready,
  input  logic [REG_ADDR_W-1:0] p_a3,
  input  logic [DATA_W-1:0]     p_wd,
  input  logic [DATA_W-1:0]     p_pc,
  input  logic                  m_valid,
  output logic                  m_ready,
  input  logic [REG_ADDR_W-1:0] m_a3,
  input  logic [DATA_W-1:0]     m_wd,
  input  logic [DATA_W-1:0]     m_pc,
  output logic                  grf_we,
  output logic [REG_ADDR_W-1:0] grf_a3,
  output logic [DATA_W-1:0]     grf_wd,
  output logic [DATA_W-1:0]     grf_pc,
  output logic                  grf_src,
  output logic                  m_starved
);

  wr_req_t p_req, m_req, win_req;
  logic    p_gnt, m_gnt, xfer;
  src_e    win;

  wr_req_t req_q, req_d;
  logic    we_q, we_d;
  src_e    src_q, src_d;

  assign p_req = {p_a3, p_wd, p_pc};
  assign m_req = {m_a3, m_wd, m_pc};

`ifdef GRF_ARB_RR_EN
  // The last-owner register is only consulted by round-robin arbitration.
  src_e last_owner_q, last_owner_d;

  // Remember the most recent winner so the other side goes next on a tie.
  always_comb begin
    last_owner_d = last_owner_q;
    if (xfer) begin
      last_owner_d = win;
    end
  end

  // Last-owner register; M by default so P takes the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_q <= SRC_M;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

  assign m_starved = 1'b0;
`else
  logic force_m;

  grf_arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk_i       (clk),
    .reset_i     (reset),
    .m_valid_i   (m_valid),
    .m_ready_i   (m_ready),
    .force_o     (force_m),
    .m_starved_o (m_starved)
  );
`endif

  // Grant: a lone requester always wins; ties are resolved by the policy.
  always_comb begin
    p_gnt = 1'b0;
    m_gnt = 1'b0;
    if (p_valid && m_valid) begin
`ifdef GRF_ARB_RR_EN
      if (last_owner_q == SRC_P) begin
        m_gnt = 1'b1;
      end else begin
        p_gnt = 1'b1;
      end
`else
      if (force_m) begin
        m_gnt = 1'b1;
      end else begin
        p_gnt = 1'b1;
      end
`endif
    end else begin
      p_gnt = p_valid;
      m_gnt = m_valid;
    end
  end

  assign p_ready = p_gnt;
  assign m_ready = m_gnt;
  assign xfer    = p_gnt || m_gnt;
  assign win     = m_gnt ? SRC_M : SRC_P;
  assign win_req = m_gnt ? m_req : p_req;

  // Output next-state: load the winner, pulse we only for a non-$0 target.
  always_comb begin
    we_d  = 1'b0;
    src_d = src_q;
    req_d = req_q;
    if (xfer) begin
      we_d  = is_real_write(win_req.a3);
      src_d = win;
      req_d = win_req;
    end
  end

  // GRF write-port output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q  <= 1'b0;
      src_q <= SRC_P;
      req_q <= '0;
    end else begin
      we_q  <= we_d;
      src_q <= src_d;
      req_q <= req_d;
    end
  end

  assign grf_we  = we_q;
  assign grf_a3  = req_q.a3;
  assign grf_wd  = req_q.wd;
  assign grf_pc  = req_q.pc;
  assign grf_src = src_q;

endmodule

// File: doc/grf_write_arbiter.md
# grf_write_arbiter

Shares the single GRF write port between two writeback requesters: the main pipeline writeback stage (P) and the multiply/divide unit (M). It sits directly in front of the GRF write port and presents one registered write (enable, address, data, PC) per cycle. It back-pressures the loser through a valid/ready handshake. A starvation guard, or optionally round-robin, keeps M from being locked out by a busy pipeline.

## Interface
- MAX_WAIT, 4, consecutive cycles M may be refused in fixed-priority mode before it is force-granted (1..7)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- p_valid  in  1  pipeline has a write pending
- p_ready  out  1  pipeline write accepted this cycle (combinational)
- p_a3  in  5  pipeline destination register
- p_wd  in  32  pipeline write data
- p_pc  in  32  PC of the writing instruction
- m_valid  in  1  M unit has a write pending
- m_ready  out  1  M write accepted this cycle (combinational)
- m_a3 / m_wd / m_pc  in  5 / 32 / 32  M destination, data, PC
- grf_we  out  1  GRF write enable (registered)
- grf_a3  out  5  GRF write address (registered)
- grf_wd  out  32  GRF write data (registered)
- grf_pc  out  32  PC for GRF write trace (registered)
- grf_src  out  1  source of the current grf_* write: 0 = P, 1 = M (registered)
- m_starved  out  1  wait counter at MAX_WAIT (registered)

## Operation
- Grant is a combinational function of p_valid, m_valid, the wait counter and the last-owner register. At most one of p_ready and m_ready is high. Ready is never high without the matching valid.
- Transfer: valid && ready at a rising clk edge. At that edge grf_a3, grf_wd, grf_pc and grf_src load the winner's payload.
  - grf_we loads 1 if the winner's a3 != 0.
  - grf_we loads 0 if the winner's a3 == 0. The handshake still completes and the $0 write is silently dropped.
- With no transfer at an edge, grf_we loads 0. The other grf_* outputs hold their values.
- Requesters hold valid and a stable payload until ready. Dropping valid early or changing the payload early is a protocol violation; behaviour is undefined.
- Fixed priority (default):
  - P alone: P wins. M alone: M wins.
  - Both valid: P wins, unless wait_cnt == MAX_WAIT, in which case M wins.
- wait_cnt (3 bits):
  - Increments each edge where m_valid && !m_ready, saturating at MAX_WAIT.
  - Clears on any M transfer.
  - Holds when m_valid is low.
- last_owner register: updates to the winner on every transfer.
- Reset values: grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0, grf_src=0, m_starved=0, wait_cnt=0, last_owner=M.
- Reset asserted mid-transfer: the in-flight transfer is lost and outputs clear immediately (asynchronous). The requester re-presents after reset.

## Timing
- Latency: one cycle. A transfer at edge N drives grf_we/grf_a3/grf_wd during cycle N+1, and the GRF commits at edge N+1.
- Throughput: one write per cycle. Back-to-back transfers from the same or alternating sources have no bubble.
- p_ready and m_ready depend only on current inputs and registered state. There is no path from grf_* to ready.
- m_starved rises the cycle after wait_cnt reaches MAX_WAIT. It falls the cycle after the forced M transfer.

## Configuration
- GRF_ARB_RR_EN defined:
  - Round-robin. When both are valid, the source that is not last_owner wins; a single valid source wins as in fixed-priority mode.
  - wait_cnt and the force-grant logic are compiled out, and m_starved is tied to 0.
- GRF_ARB_RR_EN undefined: fixed priority with the starvation guard, as described above.

## Structure
- Package grf_arb_pkg holds:
  - Source encodings SRC_P=1'b0 and SRC_M=1'b1.
  - REG_ADDR_W=5, DATA_W=32.
  - The wait-counter width constant.
- Sub-module grf_arb_wait_ctr: the saturating wait counter and the m_starved flag, instantiated only when GRF_ARB_RR_EN is undefined.
- Top level holds the grant logic, last_owner register and output registers.

## Test plan
- Reset then idle: grf_we=0 and all grf_* = 0. Then assert reset asynchronously mid-cycle during a transfer: outputs clear before the next edge.
- P alone writes a3=5, wd=0x1234, pc=0x3000: p_ready=1 in the same cycle. Next cycle grf_we=1, grf_a3=5, grf_wd=0x1234, grf_pc=0x3000, grf_src=0.
- Write with a3=0 from M: m_ready=1 and the handshake completes. Next cycle grf_we=0, grf_src=1.
- Fixed priority, MAX_WAIT=4, P and M valid continuously:
  - P wins 4 cycles while wait_cnt counts 1..4.
  - On the 5th cycle m_ready=1 and p_ready=0; the M write appears the following cycle.
  - wait_cnt then returns to 0.
- GRF_ARB_RR_EN defined, P and M valid continuously from reset: grants alternate P, M, P, M. grf_src toggles every cycle with grf_we=1 throughout.
- M valid alone for 3 cycles, then P joins: M transfers each cycle with no bubble. Afterwards P wins (fixed mode) and M sees m_ready=0 with its payload held.
